// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request path and elevator_controller:
// floor count, debounce defaults and the request-vector types.
package elevator_pkg;

    localparam int NUM_FLOORS      = 4;
    localparam int FLOOR_BITS      = 2;
    localparam int DEBOUNCE_CYCLES = 3;
    localparam int CNT_BITS        = 2;

    typedef logic [FLOOR_BITS-1:0] floor_t;
    typedef logic [NUM_FLOORS-1:0] req_vec_t;

    // Which panel a button line comes from.
    typedef enum logic [1:0] {
        BTN_CAB  = 2'd0,
        BTN_UP   = 2'd1,
        BTN_DOWN = 2'd2
    } btn_kind_t;

    // The top floor has no up call and the ground floor has no down call;
    // those request bits are held at zero.
    function automatic logic line_exists(btn_kind_t kind, int floor, int num_floors);
        case (kind)
            BTN_UP:   return floor != num_floors - 1;
            BTN_DOWN: return floor != 0;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw button line: 2-flop synchronizer, saturating run counter,
// debounced level and a one-cycle press pulse on its rising edge.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_BITS        = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic press_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES);

    logic                sync1_q, s_q;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                db_q, db_d;

    // Count consecutive synchronized-high cycles; the level is accepted in the
    // same cycle the count reaches its limit so the press can latch on that edge.
    always_comb begin
        cnt_d = '0;
        if (s_q) begin
            if (cnt_q >= CNT_MAX) cnt_d = CNT_MAX;
            else                  cnt_d = cnt_q + CNT_BITS'(1);
        end
        db_d    = s_q & (db_q | (cnt_d == CNT_MAX));
        press_o = db_d & ~db_q;
    end

    // Synchronizer, counter and debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            s_q     <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

endmodule

// File: rtl/elevator_request_latch.sv
// Turns raw cab and hall buttons into pending-request bits that stay set
// until the controller serves the floor. Feeds elevator_controller directly.
module elevator_request_latch #(
    parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_BITS      = elevator_pkg::FLOOR_BITS,
    parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES,
    parameter int CNT_BITS        = elevator_pkg::CNT_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_internal,
    input  logic [NUM_FLOORS-1:0] btn_up,
    input  logic [NUM_FLOORS-1:0] btn_down,
    input  logic                  serve_valid,
    input  logic [FLOOR_BITS-1:0] serve_floor,
    input  logic                  serve_up,
    input  logic                  serve_down,
    output logic [NUM_FLOORS-1:0] internal_requests,
    output logic [NUM_FLOORS-1:0] external_up_requests,
    output logic [NUM_FLOORS-1:0] external_down_requests,
    output logic                  any_request
);

    import elevator_pkg::line_exists;
    import elevator_pkg::BTN_UP;
    import elevator_pkg::BTN_DOWN;

    logic [NUM_FLOORS-1:0] press_int, press_up, press_down;
    logic [NUM_FLOORS-1:0] clr_floor, up_keep, down_keep;
    logic [NUM_FLOORS-1:0] int_q, int_d, up_q, up_d, down_q, down_d;
    logic                  any_q, any_d;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS)
        ) u_int (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (btn_internal[f]),
            .press_o(press_int[f])
        );

        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS)
        ) u_up (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (btn_up[f]),
            .press_o(press_up[f])
        );

        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS)
        ) u_down (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (btn_down[f]),
            .press_o(press_down[f])
        );

        // An out-of-range serve_floor matches no index, so it clears nothing.
        assign clr_floor[f] = serve_valid && (serve_floor == FLOOR_BITS'(f));
        assign up_keep[f]   = line_exists(BTN_UP, f, NUM_FLOORS);
        assign down_keep[f] = line_exists(BTN_DOWN, f, NUM_FLOORS);
    end

    // Set on press, clear on serve; clear wins because the door is already open.
    always_comb begin
        int_d  = (int_q | press_int) & ~clr_floor;
        up_d   = (up_q | press_up) & ~(clr_floor & {NUM_FLOORS{serve_up}}) & up_keep;
        down_d = (down_q | press_down) & ~(clr_floor & {NUM_FLOORS{serve_down}}) & down_keep;
        any_d  = |{int_d, up_d, down_d};
    end

    // Pending-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_q  <= '0;
            up_q   <= '0;
            down_q <= '0;
            any_q  <= 1'b0;
        end else begin
            int_q  <= int_d;
            up_q   <= up_d;
            down_q <= down_d;
            any_q  <= any_d;
        end
    end

    assign internal_requests      = int_q;
    assign external_up_requests   = up_q;
    assign external_down_requests = down_q;
    assign any_request            = any_q;

endmodule

// File: tb/tb_elevator_request_latch.sv
// Bench for elevator_request_latch: stimulus table, directed corner-case
// sequences and random traffic, all checked against a window-based model.
module tb_elevator_request_latch;

    localparam int DC = 3;

    logic       clk;
    logic       rst, sv, su, sd;
    logic [1:0] sf;
    logic [3:0] bi, bu, bd;
    logic [3:0] o_int, o_up, o_dn;
    logic       o_any;
    logic [2:0] t_int, t_up, t_dn;
    logic       t_any;

    elevator_request_latch dut (
        .clk(clk), .reset(rst),
        .btn_internal(bi), .btn_up(bu), .btn_down(bd),
        .serve_valid(sv), .serve_floor(sf), .serve_up(su), .serve_down(sd),
        .internal_requests(o_int), .external_up_requests(o_up),
        .external_down_requests(o_dn), .any_request(o_any)
    );

    // Three-floor build so a 2-bit serve_floor can point past the last floor.
    elevator_request_latch #(.NUM_FLOORS(3), .FLOOR_BITS(2)) dut3 (
        .clk(clk), .reset(rst),
        .btn_internal(bi[2:0]), .btn_up(bu[2:0]), .btn_down(bd[2:0]),
        .serve_valid(sv), .serve_floor(sf), .serve_up(su), .serve_down(sd),
        .internal_requests(t_int), .external_up_requests(t_up),
        .external_down_requests(t_dn), .any_request(t_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        else
            n_pass++;
    endtask

    // Reference model: a press is accepted at edge t when the raw line was
    // sampled high on the DC edges t-DC-1..t-2, all after the last reset edge,
    // and was not already high on the edge just before that window.
    logic [11:0] hist [0:4095];
    int          cyc      = 0;
    int          last_rst = 0;
    logic [3:0]  m_int = '0, m_up = '0, m_dn = '0;
    logic        m_any = 1'b0;

    task automatic model_step();
        logic [11:0] ev;
        logic [3:0]  ni, nu, nd;
        logic        ok;
        int          j;
        cyc++;
        hist[cyc] = {bd, bu, bi};
        if (rst) begin
            last_rst = cyc;
            m_int = '0; m_up = '0; m_dn = '0; m_any = 1'b0;
        end else begin
            for (int b = 0; b < 12; b++) begin
                ok = 1'b1;
                for (int k = 2; k <= DC + 1; k++) begin
                    j = cyc - k;
                    if (j <= last_rst)      ok = 1'b0;
                    else if (!hist[j][b])   ok = 1'b0;
                end
                j = cyc - DC - 2;
                if (j > last_rst && hist[j][b]) ok = 1'b0;
                ev[b] = ok;
            end
            ni = m_int | ev[3:0];
            nu = (m_up | ev[7:4]) & 4'b0111;
            nd = (m_dn | ev[11:8]) & 4'b1110;
            if (sv) begin
                ni[sf] = 1'b0;
                if (su) nu[sf] = 1'b0;
                if (sd) nd[sf] = 1'b0;
            end
            m_int = ni; m_up = nu; m_dn = nd;
            m_any = |{ni, nu, nd};
        end
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_int", 32'(o_int), 32'(m_int));
        chk("model_up",  32'(o_up),  32'(m_up));
        chk("model_dn",  32'(o_dn),  32'(m_dn));
        chk("model_any", 32'(o_any), 32'(m_any));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] bi, bu, bd;
        logic       sv;
        logic [1:0] sf;
        logic       su, sd;
        int         reps;
        logic [3:0] ei, eu, ed;
        logic       ea;
    } vec_t;

    function automatic vec_t mk(logic r, logic [3:0] i, logic [3:0] u, logic [3:0] d,
                                logic v, logic [1:0] f, logic fu, logic fd, int n,
                                logic [3:0] xi, logic [3:0] xu, logic [3:0] xd, logic xa);
        vec_t t;
        t.rst = r; t.bi = i; t.bu = u; t.bd = d; t.sv = v; t.sf = f; t.su = fu; t.sd = fd;
        t.reps = n; t.ei = xi; t.eu = xu; t.ed = xd; t.ea = xa;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1; sv = 1'b0; su = 1'b0; sd = 1'b0; sf = '0;
        bi = '0; bu = '0; bd = '0;

        //             rst  int     up      down    sv f  su sd reps  e_int   e_up    e_down  any
        tbl.push_back(mk(1, 4'h0,  4'h0,  4'h0,  0, 0, 0, 0, 2,  4'h0,  4'h0,  4'h0,  0));
        tbl.push_back(mk(0, 4'h4,  4'h0,  4'h0,  0, 0, 0, 0, 4,  4'h0,  4'h0,  4'h0,  0));
        tbl.push_back(mk(0, 4'h4,  4'h0,  4'h0,  0, 0, 0, 0, 1,  4'h4,  4'h0,  4'h0,  1));
        tbl.push_back(mk(0, 4'h0,  4'h0,  4'h0,  0, 0, 0, 0, 3,  4'h4,  4'h0,  4'h0,  1));
        tbl.push_back(mk(0, 4'h0,  4'h2,  4'h0,  0, 0, 0, 0, 2,  4'h4,  4'h0,  4'h0,  1));
        tbl.push_back(mk(0, 4'h0,  4'h0,  4'h0,  0, 0, 0, 0, 10, 4'h4,  4'h0,  4'h0,  1));
        tbl.push_back(mk(0, 4'h0,  4'h4,  4'h8,  0, 0, 0, 0, 4,  4'h4,  4'h0,  4'h0,  1));
        tbl.push_back(mk(0, 4'h0,  4'h0,  4'h0,  0, 0, 0, 0, 1,  4'h4,  4'h4,  4'h8,  1));
        tbl.push_back(mk(0, 4'h0,  4'h0,  4'h0,  1, 2, 1, 0, 1,  4'h0,  4'h0,  4'h8,  1));
        tbl.push_back(mk(0, 4'h0,  4'h0,  4'h0,  0, 0, 0, 0, 2,  4'h0,  4'h0,  4'h8,  1));

        foreach (tbl[r]) begin
            rst = tbl[r].rst; bi = tbl[r].bi; bu = tbl[r].bu; bd = tbl[r].bd;
            sv = tbl[r].sv; sf = tbl[r].sf; su = tbl[r].su; sd = tbl[r].sd;
            for (int k = 0; k < tbl[r].reps; k++) begin
                tick();
                chk("tbl_int", 32'(o_int), 32'(tbl[r].ei));
                chk("tbl_up",  32'(o_up),  32'(tbl[r].eu));
                chk("tbl_dn",  32'(o_dn),  32'(tbl[r].ed));
                chk("tbl_any", 32'(o_any), 32'(tbl[r].ea));
            end
        end
        chk("n3_up_top_masked", 32'(t_up), 32'h0);

        // Held hall-down call is served and must not re-latch until re-pressed.
        bd[1] = 1'b1;
        repeat (5) tick();
        chk("hold_set", 32'(o_dn[1]), 32'h1);
        sv = 1'b1; sf = 2'd1; su = 1'b0; sd = 1'b1;
        tick();
        sv = 1'b0; sd = 1'b0;
        chk("serve_while_held", 32'(o_dn[1]), 32'h0);
        repeat (10) begin
            tick();
            chk("held_no_relatch", 32'(o_dn[1]), 32'h0);
        end
        bd[1] = 1'b0;
        repeat (3) tick();
        bd[1] = 1'b1;
        repeat (5) tick();
        chk("repress_set", 32'(o_dn[1]), 32'h1);
        bd[1] = 1'b0;

        // Press event and serve on the same edge: clear wins, no later event.
        bi[1] = 1'b1;
        repeat (4) tick();
        sv = 1'b1; sf = 2'd1;
        tick();
        sv = 1'b0;
        chk("set_clr_same_edge", 32'(o_int[1]), 32'h0);
        repeat (3) begin
            tick();
            chk("no_late_event", 32'(o_int[1]), 32'h0);
        end
        bi[1] = 1'b0;
        tick();

        // Out-of-range serve on the three-floor build.
        bi[2] = 1'b1;
        repeat (5) tick();
        bi[2] = 1'b0;
        chk("n3_set", 32'(t_int), 32'h4);
        sv = 1'b1; sf = 2'd3; su = 1'b1; sd = 1'b1;
        tick();
        chk("n3_oor_int", 32'(t_int), 32'h4);
        chk("n3_oor_any", 32'(t_any), 32'h1);
        sf = 2'd2; su = 1'b0; sd = 1'b0;
        tick();
        sv = 1'b0;
        chk("n3_clr", 32'(t_int), 32'h0);
        chk("n3_down_kept", 32'(t_dn), 32'h2);

        // Lines that have no request bit.
        bu[3] = 1'b1; bd[0] = 1'b1;
        repeat (6) begin
            tick();
            chk("masked_up3", 32'(o_up[3]), 32'h0);
            chk("masked_dn0", 32'(o_dn[0]), 32'h0);
        end
        bu[3] = 1'b0; bd[0] = 1'b0;

        // Reset with requests pending, cab button 0 held across the release.
        bi[0] = 1'b1; bu[1] = 1'b1; bd[2] = 1'b1;
        repeat (5) tick();
        chk("three_pending", 32'({o_int[0], o_up[1], o_dn[2]}), 32'h7);
        bu[1] = 1'b0; bd[2] = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_int", 32'(o_int), 32'h0);
        chk("rst_up",  32'(o_up),  32'h0);
        chk("rst_dn",  32'(o_dn),  32'h0);
        chk("rst_any", 32'(o_any), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= DC + 2; i++) begin
            tick();
            chk("hold_across_rst", 32'(o_int[0]), (i == DC + 2) ? 32'h1 : 32'h0);
        end
        bi[0] = 1'b0;

        // Random traffic: slow button toggles, sporadic serves and resets.
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) bi[b] = ~bi[b];
                if ($urandom_range(5) == 0) bu[b] = ~bu[b];
                if ($urandom_range(5) == 0) bd[b] = ~bd[b];
            end
            sv  = ($urandom_range(7) == 0);
            sf  = 2'($urandom_range(3));
            su  = 1'($urandom_range(1));
            sd  = 1'($urandom_range(1));
            rst = ($urandom_range(299) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/elevator_request_latch.md
Name: elevator_request_latch

Overview:
Upstream stage of elevator_controller. It takes the raw cab and hall button lines and, for each one:
- synchronizes it and debounces it;
- converts it into a press event;
- holds a pending-request bit until the controller reports that the floor has been served.

Its registered outputs drive elevator_controller's internal_requests, external_up_requests and external_down_requests directly.

Parameters:
NUM_FLOORS, 4, number of floors served
FLOOR_BITS, 2, width of a floor index (clog2 of NUM_FLOORS)
DEBOUNCE_CYCLES, 3, consecutive synchronized-high samples needed to accept a press (must be at least 1)
CNT_BITS, 2, debounce counter width (must hold DEBOUNCE_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_internal  in  NUM_FLOORS  raw cab buttons, asynchronous
btn_up  in  NUM_FLOORS  raw hall-up buttons, asynchronous
btn_down  in  NUM_FLOORS  raw hall-down buttons, asynchronous
serve_valid  in  1  one-cycle pulse from controller when the doors open at a floor
serve_floor  in  FLOOR_BITS  floor being served, qualified by serve_valid
serve_up  in  1  clear the hall-up call at serve_floor
serve_down  in  1  clear the hall-down call at serve_floor
internal_requests  out  NUM_FLOORS  pending cab requests, registered
external_up_requests  out  NUM_FLOORS  pending hall-up requests, registered
external_down_requests  out  NUM_FLOORS  pending hall-down requests, registered
any_request  out  1  OR of all pending bits, registered

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset:
  - all outputs go to 0;
  - all synchronizer flops, debounce counters and debounced levels go to 0.
- Per-button pipeline:
  - 2-flop synchronizer produces s.
  - Counter cnt: cnt <= 0 when s=0; otherwise cnt <= min(cnt+1, DEBOUNCE_CYCLES).
  - Debounced level db is set on the edge where cnt reaches DEBOUNCE_CYCLES. db is cleared on the edge where s=0.
  - press event = the cycle db goes 0->1. Exactly one event is produced per press.
- Latency: raw line first sampled high at edge n and held → pending bit reads 1 after edge n+DEBOUNCE_CYCLES+1. With the default, that is 4 edges after first sample.
- Glitches: a raw pulse shorter than DEBOUNCE_CYCLES clocks produces no event.
- Holding a button: produces no further events. After the request is served, a new request needs a release of at least 1 synchronized cycle plus a fresh debounced press.
- Latch: a pending bit is set by a press event and held until cleared.
- Clearing when serve_valid=1 and serve_floor<NUM_FLOORS:
  - internal_requests[serve_floor] is always cleared;
  - external_up_requests[serve_floor] is cleared if serve_up=1;
  - external_down_requests[serve_floor] is cleared if serve_down=1.
- Out of range: serve_floor ≥ NUM_FLOORS is ignored, with no clears.
- Simultaneous set and clear of the same bit: clear wins. The passenger is already at an open door.
- Masked bits: external_up_requests[NUM_FLOORS-1] and external_down_requests[0] are constant 0. Presses on those lines are discarded.
- Independence: different bits never interact. Presses on several buttons in the same cycle all latch.
- any_request is computed from the next-state values of the pending bits, so it matches the outputs in the same cycle.
- Reset mid-operation: all pending bits are lost. A button still held when reset deasserts re-debounces from cnt=0 and then latches one event, because db was reset to 0.

Decomposition:
- Shared package elevator_pkg holds:
  - NUM_FLOORS, FLOOR_BITS and the DEBOUNCE_CYCLES default, shared with elevator_controller;
  - floor-index and request-vector typedefs.
- One sub-module, button_debouncer, contains the synchronizer, counter, db and edge detect, and outputs a one-cycle press.
- The top module instantiates button_debouncer 3×NUM_FLOORS times, plus the latch and clear logic.

Test Plan:
- Reset, then btn_internal[2] held 5 cycles → internal_requests=4'b0100 after edge n+4; any_request=1; bit stays set after release.
- 2-cycle glitch on btn_up[1] → external_up_requests stays 4'b0000 for the next 10 cycles.
- Pending internal[2] and up[2]; pulse serve_valid, serve_floor=2, serve_up=1, serve_down=0 → both bits 0 next cycle; an unrelated pending down[3] stays 1.
- btn_down[1] held continuously; serve floor 1 with serve_down=1 → bit cleared and never re-set while held. Release 3 cycles, press again for 5 cycles → bit re-sets.
- Press event on internal[1] lands in the same cycle as serve_valid at floor 1 → bit remains 0. Serve with serve_floor=3 while NUM_FLOORS=3 → no change.
- btn_up[3] and btn_down[0] pressed → outputs stay 0. Assert reset with 3 bits pending → all outputs 0 next cycle. btn_internal[0] held across reset release → bit sets DEBOUNCE_CYCLES+2 edges after release.
